mb_serial_crc_rx: RTL and testbench

//  Receive end of the CRC-protected serial link. Deserialises frames from the transmitter,

---
 rtl/mb_serial_pkg.sv | 21 ++
 rtl/mb_serial_crc_rx_if.sv | 34 +++
 rtl/mb_crc_lfsr.sv | 42 ++++
 rtl/mb_serial_crc_rx.sv | 137 +++++++++++++
 tb/tb_mb_serial_crc_rx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mb_serial_pkg.sv
// Shared definitions for the CRC-protected serial link (receiver and transmitter).
package mb_serial_pkg;

   // Receiver frame phase
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRCB = 2'd2,
      STOP = 2'd3
   } state_e;

   // Default link geometry: 8-bit payload, CRC-4 with x^4+x+1
   localparam int           DEF_DATA_W   = 8;
   localparam int           DEF_CRC_W    = 4;
   localparam logic [3:0]   DEF_CRC_POLY = 4'h3;

   // Line levels
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/mb_serial_crc_rx_if.sv
// Line-side inputs and payload-side outputs of the serial CRC receiver.
//
// Signalling: SIN is only meaningful on CLK edges where BIT_EN=1 (one line
// bit per strobe, no back-pressure). DVALID, CRC_ERR and FRAME_ERR are
// single-cycle, mutually exclusive pulses with no ready; the consumer must
// take DOUT in the cycle DVALID is high or read the held value later.
// BUSY is high while a frame is in flight, from the start bit to the stop bit.
interface mb_serial_crc_rx_if
   import mb_serial_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              BIT_EN;
   logic              SIN;
   logic [DATA_W-1:0] DOUT;
   logic              DVALID;
   logic              CRC_ERR;
   logic              FRAME_ERR;
   logic              BUSY;

   // Line/consumer side
   modport master (
      output BIT_EN, SIN,
      input  DOUT, DVALID, CRC_ERR, FRAME_ERR, BUSY
   );

   // Receiver side
   modport slave (
      input  BIT_EN, SIN,
      output DOUT, DVALID, CRC_ERR, FRAME_ERR, BUSY
   );

endinterface

// File: rtl/mb_crc_lfsr.sv
// Serial CRC step: non-reflected LFSR, one bit per enable, synchronous clear.
module mb_crc_lfsr
   import mb_serial_pkg::*;
#(
   parameter int               CRC_W    = DEF_CRC_W,
   parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(DEF_CRC_POLY)
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             clear,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_d;
   logic             fb;

   // Next LFSR value: clear wins over a shift step
   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[CRC_W-1] ^ din;
      if (clear) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = (crc_q << 1) ^ (fb ? CRC_POLY : '0);
      end
   end

   // LFSR register
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/mb_serial_crc_rx.sv
// Receive end of the CRC-protected serial link: deframes start/data/CRC/stop,
// checks for a zero CRC remainder and reports good payloads or errors.
module mb_serial_crc_rx
   import mb_serial_pkg::*;
#(
   parameter int               DATA_W   = DEF_DATA_W,
   parameter int               CRC_W    = DEF_CRC_W,
   parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(DEF_CRC_POLY)
) (
   input  logic                CLK,
   input  logic                CLR,
   mb_serial_crc_rx_if.slave   bus,
   output state_e              dbg_state
);

   localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic [DATA_W-1:0]  dout_q, dout_d;
   logic               dvalid_q, dvalid_d;
   logic               crc_err_q, crc_err_d;
   logic               frame_err_q, frame_err_d;

   logic               lfsr_clear;
   logic               lfsr_en;
   logic [CRC_W-1:0]   crc;

   mb_crc_lfsr #(
      .CRC_W    (CRC_W),
      .CRC_POLY (CRC_POLY)
   ) u_lfsr (
      .CLK   (CLK),
      .CLR   (CLR),
      .clear (lfsr_clear),
      .en    (lfsr_en),
      .din   (bus.SIN),
      .crc   (crc)
   );

   // Frame FSM, bit counter, payload shift and result pulses; all advance only on BIT_EN
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      dout_d      = dout_q;
      dvalid_d    = 1'b0;
      crc_err_d   = 1'b0;
      frame_err_d = 1'b0;
      lfsr_clear  = 1'b0;
      lfsr_en     = 1'b0;
      if (bus.BIT_EN) begin
         case (state_q)
            IDLE: begin
               if (bus.SIN == START_LEVEL) begin
                  state_d    = DATA;
                  cnt_d      = '0;
                  lfsr_clear = 1'b1;
               end
            end
            DATA: begin
               shift_d = {shift_q[DATA_W-2:0], bus.SIN};
               lfsr_en = 1'b1;
               if (cnt_q == DATA_LAST) begin
                  cnt_d   = '0;
                  state_d = CRCB;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            CRCB: begin
               lfsr_en = 1'b1;
               if (cnt_q == CRC_LAST) begin
                  cnt_d   = '0;
                  state_d = STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STOP: begin
               // A low stop bit is a framing error, never a new start bit
               state_d = IDLE;
               cnt_d   = '0;
               if (bus.SIN == IDLE_LEVEL) begin
                  if (crc == '0) begin
                     dout_d   = shift_q;
                     dvalid_d = 1'b1;
                  end else begin
                     crc_err_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         dout_q      <= '0;
         dvalid_q    <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         dout_q      <= dout_d;
         dvalid_q    <= dvalid_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.DOUT      = dout_q;
   assign bus.DVALID    = dvalid_q;
   assign bus.CRC_ERR   = crc_err_q;
   assign bus.FRAME_ERR = frame_err_q;
   // BUSY also covers the cycle in which the start bit is on the line and strobed
   assign bus.BUSY      = CLR && ((state_q != IDLE) ||
                                  (bus.BIT_EN && (bus.SIN == START_LEVEL)));
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mb_serial_crc_rx.sv
// Self-checking bench for mb_serial_crc_rx: directed frames plus random frames
// scored against a polynomial-division CRC model and an expected-event queue.
module tb_mb_serial_crc_rx;
   import mb_serial_pkg::*;

   localparam int               DATA_W     = 8;
   localparam int               CRC_W      = 4;
   localparam logic [CRC_W-1:0] POLY       = 4'h3;
   localparam int               FRAME_BITS = 2 + DATA_W + CRC_W;
   localparam logic [1:0]       K_GOOD     = 2'd0;
   localparam logic [1:0]       K_CRC      = 2'd1;
   localparam logic [1:0]       K_FRAME    = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mb_serial_crc_rx_if #(.DATA_W(DATA_W)) bus ();
   state_e dbg_state;

   mb_serial_crc_rx #(
      .DATA_W   (DATA_W),
      .CRC_W    (CRC_W),
      .CRC_POLY (POLY)
   ) dut (
      .CLK       (clk),
      .CLR       (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int busy_cnt = 0;
   logic [DATA_W+1:0] exp_q[$];      // {kind, payload}
   int                exp_cyc_q[$];  // cycle in which the pulse must be seen
   int                dv_cyc_q[$];   // cycles where DVALID was observed
   logic [DATA_W-1:0] model_dout = '0;
   logic [DATA_W+1:0] mon_e;
   int                mon_ec;
   logic [2:0]        mon_kind_bits;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference CRC: remainder of (data * x^CRC_W) modulo the full generator
   function automatic logic [CRC_W-1:0] ref_crc(input logic [DATA_W-1:0] d);
      logic [DATA_W+CRC_W-1:0] v;
      logic [CRC_W:0]          g;
      v = {d, {CRC_W{1'b0}}};
      g = {1'b1, POLY};
      for (int i = DATA_W + CRC_W - 1; i >= CRC_W; i--) begin
         if (v[i]) v[i -: CRC_W+1] = v[i -: CRC_W+1] ^ g;
      end
      return v[CRC_W-1:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         model_dout = '0;
      end else begin
         if (bus.BUSY) busy_cnt++;
         check("one_pulse_at_most",
               64'(($countones({bus.DVALID, bus.CRC_ERR, bus.FRAME_ERR}) <= 1)), 64'd1);
         if (bus.DVALID || bus.CRC_ERR || bus.FRAME_ERR) begin
            check("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               mon_e  = exp_q.pop_front();
               mon_ec = exp_cyc_q.pop_front();
               case (mon_e[DATA_W+1:DATA_W])
                  K_GOOD:  mon_kind_bits = 3'b100;
                  K_CRC:   mon_kind_bits = 3'b010;
                  default: mon_kind_bits = 3'b001;
               endcase
               check("pulse_kind", {bus.DVALID, bus.CRC_ERR, bus.FRAME_ERR}, mon_kind_bits);
               check("pulse_cycle", cyc, mon_ec);
               if (mon_e[DATA_W+1:DATA_W] == K_GOOD) model_dout = mon_e[DATA_W-1:0];
            end
            check("state_after_stop", dbg_state, IDLE);
            if (bus.DVALID) dv_cyc_q.push_back(cyc);
         end
         check("dout_hold", bus.DOUT, model_dout);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b, input int period, input bit noise);
      for (int p = 0; p < period; p++) begin
         @(posedge clk);
         #1;
         if (p == period - 1) begin
            bus.BIT_EN = 1'b1;
            bus.SIN    = b;
         end else begin
            bus.BIT_EN = 1'b0;
            bus.SIN    = noise ? 1'($urandom) : IDLE_LEVEL;
         end
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic [CRC_W-1:0] c,
                             input logic stop, input int period, input bit noise);
      logic [1:0] k;
      drive_bit(START_LEVEL, period, noise);
      for (int i = DATA_W - 1; i >= 0; i--) drive_bit(d[i], period, noise);
      for (int i = CRC_W - 1; i >= 0; i--) drive_bit(c[i], period, noise);
      drive_bit(stop, period, noise);
      if (!stop)                k = K_FRAME;
      else if (c == ref_crc(d)) k = K_GOOD;
      else                      k = K_CRC;
      exp_q.push_back({k, d});
      exp_cyc_q.push_back(cyc + 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.BIT_EN = 1'b0;
         bus.SIN    = IDLE_LEVEL;
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [DATA_W-1:0] rd;
      logic [CRC_W-1:0]  rc;
      logic              rs;
      int                n0;

      bus.BIT_EN = 1'b0;
      bus.SIN    = IDLE_LEVEL;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dout",      bus.DOUT, '0);
      check("rst_dvalid",    bus.DVALID, 1'b0);
      check("rst_crc_err",   bus.CRC_ERR, 1'b0);
      check("rst_frame_err", bus.FRAME_ERR, 1'b0);
      check("rst_busy",      bus.BUSY, 1'b0);
      check("rst_state",     dbg_state, IDLE);
      check("ref_crc_a5",    ref_crc(8'hA5), 4'hB);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Good frame, strobe every cycle
      busy_cnt = 0;
      send_frame(8'hA5, 4'hB, 1'b1, 1, 1'b0);
      idle(3);
      check("t1_busy_cycles", busy_cnt, FRAME_BITS);
      check("t1_pending", exp_q.size(), 0);
      check("t1_dout", bus.DOUT, 8'hA5);

      // Wrong CRC
      send_frame(8'hA5, 4'hA, 1'b1, 1, 1'b0);
      idle(3);
      check("t2_pending", exp_q.size(), 0);
      check("t2_dout", bus.DOUT, 8'hA5);

      // Low stop bit
      send_frame(8'h3C, ref_crc(8'h3C), 1'b0, 1, 1'b0);
      idle(3);
      check("t3_pending", exp_q.size(), 0);
      check("t3_state", dbg_state, IDLE);
      check("t3_dout", bus.DOUT, 8'hA5);

      // Sparse strobes with line noise between them
      n0 = dv_cyc_q.size();
      send_frame(8'hA5, 4'hB, 1'b1, 3, 1'b1);
      idle(3);
      check("t4_dvalid_count", dv_cyc_q.size(), n0 + 1);
      check("t4_dout", bus.DOUT, 8'hA5);

      // Reset in the middle of a frame
      drive_bit(START_LEVEL, 1, 1'b0);
      for (int i = DATA_W - 1; i >= DATA_W - 5; i--) drive_bit(1'(8'h5A >> i), 1, 1'b0);
      @(posedge clk);
      #1 bus.BIT_EN = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("t5_rst_dout",  bus.DOUT, '0);
      check("t5_rst_busy",  bus.BUSY, 1'b0);
      check("t5_rst_state", dbg_state, IDLE);
      check("t5_rst_pulse", {bus.DVALID, bus.CRC_ERR, bus.FRAME_ERR}, 3'b000);
      idle(2);
      @(posedge clk);
      #1 rst_n = 1'b1;
      n0 = dv_cyc_q.size();
      send_frame(8'hA5, 4'hB, 1'b1, 1, 1'b0);
      idle(3);
      check("t5_dvalid_count", dv_cyc_q.size(), n0 + 1);
      check("t5_dout", bus.DOUT, 8'hA5);

      // Back-to-back frames
      n0 = dv_cyc_q.size();
      send_frame(8'hA5, 4'hB, 1'b1, 1, 1'b0);
      send_frame(8'h00, 4'h0, 1'b1, 1, 1'b0);
      idle(3);
      check("t6_dvalid_count", dv_cyc_q.size(), n0 + 2);
      if (dv_cyc_q.size() >= n0 + 2)
         check("t6_dvalid_gap", dv_cyc_q[n0+1] - dv_cyc_q[n0], FRAME_BITS);
      check("t6_dout", bus.DOUT, 8'h00);

      // Random frames: mixed CRC validity, stop level, strobe spacing, gaps
      for (int f = 0; f < 30; f++) begin
         rd = DATA_W'($urandom);
         rc = ($urandom_range(0, 3) == 0) ? CRC_W'($urandom) : ref_crc(rd);
         rs = ($urandom_range(0, 5) != 0);
         send_frame(rd, rc, rs, $urandom_range(1, 3), 1'b1);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(4);
      check("rand_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
